// File: rtl/popcount_frame_accumulator.sv
// Frame accumulator for per-word ones counts: sums WINDOW accepted words and
// presents total, per-word maximum and a threshold flag on a valid/ready output.
module popcount_frame_accumulator #(
    parameter  int WIDTH  = 8,
    parameter  int WINDOW = 16,
    localparam int CW     = $clog2(WIDTH + 1),
    localparam int SW     = $clog2(WIDTH * WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             flush,
    input  logic [SW-1:0]    thresh,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [SW-1:0]    m_ones,
    output logic [CW-1:0]    m_max,
    output logic             m_over
);
    localparam int NW = $clog2(WINDOW);
    localparam logic [NW-1:0] LAST_IDX = NW'(WINDOW - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state_q;
    logic [NW-1:0] word_cnt_q;
    logic [SW-1:0] acc_q;
    logic [CW-1:0] max_acc_q;
    logic          m_valid_q;
    logic [SW-1:0] m_ones_q;
    logic [CW-1:0] m_max_q;
    logic          m_over_q;

    logic [CW-1:0] pc;
    logic [SW-1:0] acc_d;
    logic [CW-1:0] max_acc_d;
    logic          accept;

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + CW'(s_data[i]);
        end
    end

    assign s_ready   = (state_q == ACCUM) && !flush;
    assign accept    = s_valid && s_ready;
    assign acc_d     = acc_q + SW'(pc);
    assign max_acc_d = (pc > max_acc_q) ? pc : max_acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            word_cnt_q <= '0;
            acc_q      <= '0;
            max_acc_q  <= '0;
            m_valid_q  <= 1'b0;
            m_ones_q   <= '0;
            m_max_q    <= '0;
            m_over_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (flush) begin
                        word_cnt_q <= '0;
                        acc_q      <= '0;
                        max_acc_q  <= '0;
                    end else if (accept) begin
                        if (word_cnt_q == LAST_IDX) begin
                            // Last word of the frame: publish and start a fresh frame.
                            m_ones_q   <= acc_d;
                            m_max_q    <= max_acc_d;
                            m_over_q   <= acc_d > thresh;
                            m_valid_q  <= 1'b1;
                            word_cnt_q <= '0;
                            acc_q      <= '0;
                            max_acc_q  <= '0;
                            state_q    <= HOLD;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            acc_q      <= acc_d;
                            max_acc_q  <= max_acc_d;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_ones  = m_ones_q;
    assign m_max   = m_max_q;
    assign m_over  = m_over_q;
endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Directed bench for popcount_frame_accumulator (WIDTH=8, WINDOW=4) with an
// expected-result queue filled as words are accepted.
module tb_popcount_frame_accumulator;
    localparam int WIDTH  = 8;
    localparam int WINDOW = 4;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int SW     = $clog2(WIDTH * WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             flush = 1'b0;
    logic [SW-1:0]    thresh = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [SW-1:0]    m_ones;
    logic [CW-1:0]    m_max;
    logic             m_over;

    typedef struct packed {
        logic [SW-1:0] ones;
        logic [CW-1:0] mx;
        logic          over;
    } res_t;

    res_t exp_q[$];
    int   m_acc = 0;
    int   m_mx  = 0;
    int   m_cnt = 0;
    int   vectors = 0;
    int   errs = 0;

    popcount_frame_accumulator #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .flush(flush), .thresh(thresh), .m_valid(m_valid),
        .m_ready(m_ready), .m_ones(m_ones), .m_max(m_max), .m_over(m_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-16s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_mx  = 0;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] d);
        int   pc;
        res_t r;
        pc = $countones(d);
        m_acc += pc;
        if (pc > m_mx) m_mx = pc;
        m_cnt++;
        if (m_cnt == WINDOW) begin
            r.ones = SW'(m_acc);
            r.mx   = CW'(m_mx);
            r.over = (m_acc > int'(thresh));
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input logic [WIDTH-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        #1;
        while (!s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            check("s_ready_wait", 32'(s_ready), 32'd1);
        end else begin
            model_accept(d);
            @(posedge clk); #1;
        end
    endtask

    task automatic bubble();
        s_valid = 1'b0;
        s_data  = WIDTH'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic expect_result(input int hold);
        res_t e;
        logic [SW-1:0] o_ones;
        logic [CW-1:0] o_max;
        logic          o_over;
        s_valid = 1'b0;
        check("latency_m_valid", 32'(m_valid), 32'd1);
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("m_ones", 32'(m_ones), 32'(e.ones));
            check("m_max", 32'(m_max), 32'(e.mx));
            check("m_over", 32'(m_over), 32'(e.over));
        end
        o_ones = m_ones; o_max = m_max; o_over = m_over;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_m_ones", 32'(m_ones), 32'(o_ones));
            check("hold_m_max", 32'(m_max), 32'(o_max));
            check("hold_m_over", 32'(m_over), 32'(o_over));
            check("hold_s_ready", 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("post_m_valid", 32'(m_valid), 32'd0);
        check("post_s_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_ones", 32'(m_ones), 32'd0);
        check("rst_m_max", 32'(m_max), 32'd0);
        check("rst_m_over", 32'(m_over), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // Basic frame, thresh=12 -> over
        thresh = 6'd12;
        send_word(8'hFF); send_word(8'h00); send_word(8'h0F); send_word(8'h01);
        expect_result(0);

        // Same frame, thresh=13 -> not over; consumer stalls 5 cycles
        thresh = 6'd13;
        send_word(8'hFF); send_word(8'h00); send_word(8'h0F); send_word(8'h01);
        expect_result(5);

        // Four 0x01 words, thresh changed only before the last word
        thresh = 6'd0;
        send_word(8'h01); send_word(8'h01); send_word(8'h01);
        thresh = 6'd13;
        send_word(8'h01);
        expect_result(1);

        // Full-scale frame
        send_word(8'hFF); send_word(8'hFF); send_word(8'hFF); send_word(8'hFF);
        expect_result(0);

        // Flush after two words
        send_word(8'hFF); send_word(8'hFF);
        s_valid = 1'b1; s_data = 8'hFF; flush = 1'b1;
        #1;
        check("flush_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        send_word(8'h03); send_word(8'h03); send_word(8'h03); send_word(8'h03);
        expect_result(0);

        // Bubbles: valid pattern 1,0,0,1,0,1,1
        send_word(8'h80); bubble(); bubble(); send_word(8'h80); bubble();
        check("bubble_m_valid", 32'(m_valid), 32'd0);
        send_word(8'h80); send_word(8'h80);
        expect_result(0);
        bubble();
        check("one_frame_only", 32'(m_valid), 32'd0);

        // Async reset mid-frame
        send_word(8'hFF); send_word(8'hFF);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rstmid_m_valid", 32'(m_valid), 32'd0);
        check("rstmid_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        send_word(8'h01); send_word(8'h01); send_word(8'h01); send_word(8'h01);
        expect_result(0);

        // Async reset during HOLD
        send_word(8'hFF); send_word(8'h0F); send_word(8'h0F); send_word(8'h0F);
        s_valid = 1'b0;
        check("pre_rst_hold", 32'(m_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rsthold_m_valid", 32'(m_valid), 32'd0);
        check("rsthold_m_ones", 32'(m_ones), 32'd0);
        check("rsthold_m_max", 32'(m_max), 32'd0);
        check("rsthold_m_over", 32'(m_over), 32'd0);
        exp_q.delete();
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        send_word(8'h01); send_word(8'h01); send_word(8'h01); send_word(8'h01);
        expect_result(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
